seg7_capture: RTL and testbench

//   Segment-side decoder/monitor: samples NUM_DIGITS active-low 7-segment buses (HEXn[0]=a..HEXn[6]=g),

---
 rtl/seg7_capture.sv | 177 +++++++++++++++++
 tb/tb_seg7_capture.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Segment-side monitor: deglitches active-low 7-segment buses, decodes settled glyphs to nibbles,
// and reports every committed change through a round-robin valid/ready event stream.
module seg7_capture #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [2:0]              ev_digit,
    output logic [3:0]              ev_nibble,
    output logic                    ev_err
);

    localparam int unsigned PTR_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Returns {legal, nibble}; illegal patterns (blank included) map to {0, 0}.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        case (pat)
            7'h40:   decode = 5'h10;
            7'h79:   decode = 5'h11;
            7'h24:   decode = 5'h12;
            7'h30:   decode = 5'h13;
            7'h19:   decode = 5'h14;
            7'h12:   decode = 5'h15;
            7'h02:   decode = 5'h16;
            7'h78:   decode = 5'h17;
            7'h00:   decode = 5'h18;
            7'h18:   decode = 5'h19;
            7'h08:   decode = 5'h1A;
            7'h03:   decode = 5'h1B;
            7'h46:   decode = 5'h1C;
            7'h21:   decode = 5'h1D;
            7'h06:   decode = 5'h1E;
            7'h0E:   decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [6:0]              seg_q [NUM_DIGITS];
    logic [CNT_W-1:0]        cnt   [NUM_DIGITS];
    logic [5*NUM_DIGITS-1:0] dec_all;
    logic [NUM_DIGITS-1:0]   change;
    logic [NUM_DIGITS-1:0]   pending;
    logic [NUM_DIGITS-1:0]   clr_c;
    logic [PTR_W-1:0]        ptr;
    logic [31:0]             val_pad;
    logic [7:0]              ok_pad;
    logic [7:0]              pend_pad;
    state_t                  state;
    state_t                  state_nx;
    logic                    load_c;
    logic                    ack_c;
    logic                    adv_c;
    logic                    stale_c;

    // A digit settles on the edge its counter reaches STABLE_CYCLES; it commits only on a real change.
    always_comb begin
        dec_all = '0;
        change  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dec_all[5*i +: 5] = decode(seg_q[i]);
            change[i] = (seg_in[7*i +: 7] == seg_q[i]) && (cnt[i] == CNT_SET) &&
                        (decode(seg_q[i]) != {digit_ok[i], value[4*i +: 4]});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_q[i] <= 7'h7F;
                cnt[i]   <= '0;
            end
            value    <= '0;
            digit_ok <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_q[i] <= seg_in[7*i +: 7];
                if (seg_in[7*i +: 7] != seg_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (change[i]) begin
                    value[4*i +: 4] <= dec_all[5*i +: 4];
                    digit_ok[i]     <= dec_all[5*i + 4];
                end
            end
        end
    end

    assign val_pad  = 32'(value);
    assign ok_pad   = 8'(digit_ok);
    assign pend_pad = 8'(pending);

    // A commit that lands after the payload was loaded must survive the handshake.
    assign stale_c = ({~ev_err, ev_nibble} != {ok_pad[ptr], val_pad[4*ptr +: 4]});
    assign clr_c   = (ack_c && !stale_c) ? (NUM_DIGITS'(1) << ptr) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_c) | change;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SCAN:    if (pend_pad[ptr]) state_nx = HOLD;
            HOLD:    if (ev_ready) state_nx = SCAN;
            default: state_nx = SCAN;
        endcase
    end

    always_comb begin
        load_c = 1'b0;
        ack_c  = 1'b0;
        adv_c  = 1'b0;
        case (state)
            SCAN: begin
                load_c = pend_pad[ptr];
                adv_c  = !pend_pad[ptr];
            end
            HOLD: begin
                ack_c = ev_ready;
                adv_c = ev_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            ev_valid  <= 1'b0;
            ev_digit  <= '0;
            ev_nibble <= '0;
            ev_err    <= 1'b0;
        end else begin
            if (adv_c) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
            end
            if (load_c) begin
                ev_valid  <= 1'b1;
                ev_digit  <= ptr;
                ev_nibble <= val_pad[4*ptr +: 4];
                ev_err    <= !ok_pad[ptr];
            end else if (ack_c) begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: settle latency, glitch rejection, event ordering/holding and reset.
module tb_seg7_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [41:0] seg_in;
    logic [23:0] value;
    logic [5:0]  digit_ok;
    logic        ev_valid;
    logic        ev_ready;
    logic [2:0]  ev_digit;
    logic [3:0]  ev_nibble;
    logic        ev_err;

    int tests = 0;
    int fails = 0;
    int vcount = 0;
    logic [7:0] evq[$];

    seg7_capture #(.NUM_DIGITS(6), .STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .seg_in(seg_in), .value(value), .digit_ok(digit_ok),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_digit(ev_digit), .ev_nibble(ev_nibble),
        .ev_err(ev_err)
    );

    always #5 clock = ~clock;

    // Log accepted events as {err, nibble, digit} and count cycles with ev_valid high.
    always @(posedge clock) begin
        if (!reset && ev_valid) vcount++;
        if (!reset && ev_valid && ev_ready) evq.push_back({ev_err, ev_nibble, ev_digit});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [7:0] ev(input logic e, input logic [3:0] n, input logic [2:0] d);
        return {e, n, d};
    endfunction

    int n;
    int base;
    int vbase;
    logic [7:0] held;
    logic [3:0] nib_exp [6];

    initial begin
        nib_exp = '{4'h3, 4'h8, 4'hA, 4'hE, 4'h7, 4'hF};
        reset    = 1'b1;
        ev_ready = 1'b0;
        seg_in   = {6{7'h7F}};
        step(2);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_ok", 32'(digit_ok), 32'h0);
        chk("rst_valid", 32'(ev_valid), 32'h0);
        chk("rst_payload", 32'({ev_err, ev_nibble, ev_digit}), 32'h0);
        reset = 1'b0;

        // Blank inputs: blank settles onto blank, so nothing commits and no event appears.
        step(20);
        chk("blank_value", 32'(value), 32'h0);
        chk("blank_ok", 32'(digit_ok), 32'h0);
        chk("blank_vcount", 32'(vcount), 32'h0);

        // Digit 2 shows '2'; commit lands exactly STABLE_CYCLES edges after first sample.
        ev_ready = 1'b1;
        base = evq.size();
        seg_in[14 +: 7] = 7'h24;
        step(4);
        chk("d2_early_ok", 32'(digit_ok), 32'h0);
        step(1);
        chk("d2_ok", 32'(digit_ok), 32'h04);
        chk("d2_value", 32'(value), 32'h000200);
        n = 0;
        while (!ev_valid && n < 10) begin
            step(1);
            n++;
        end
        chk("d2_ev_seen", 32'(ev_valid), 32'h1);
        chk("d2_ev_latency", 32'(n <= 7), 32'h1);
        chk("d2_payload", 32'({ev_err, ev_nibble, ev_digit}), 32'(ev(1'b0, 4'h2, 3'd2)));
        step(1);
        chk("d2_ev_drop", 32'(ev_valid), 32'h0);
        step(20);
        chk("d2_ev_count", 32'(evq.size() - base), 32'h1);
        if (evq.size() > base) chk("d2_ev_logged", 32'(evq[base]), 32'(ev(1'b0, 4'h2, 3'd2)));

        // Digit 0 toggles every 2 cycles: never stable long enough, then returns to blank.
        base = evq.size();
        for (int i = 0; i < 10; i++) begin
            seg_in[0 +: 7] = 7'h40;
            step(2);
            seg_in[0 +: 7] = 7'h79;
            step(2);
        end
        seg_in[0 +: 7] = 7'h7F;
        step(10);
        chk("glitch_ok", 32'(digit_ok), 32'h04);
        chk("glitch_value", 32'(value), 32'h000200);
        chk("glitch_events", 32'(evq.size() - base), 32'h0);

        // All six digits settle on the same edge while the consumer stalls.
        ev_ready = 1'b0;
        base = evq.size();
        seg_in = {7'h0E, 7'h78, 7'h06, 7'h08, 7'h00, 7'h30};
        step(5);
        chk("all_ok", 32'(digit_ok), 32'h3F);
        chk("all_value", 32'(value), 32'hF7EA83);
        step(10);
        chk("stall_valid", 32'(ev_valid), 32'h1);
        held = {ev_err, ev_nibble, ev_digit};
        step(5);
        chk("stall_valid_kept", 32'(ev_valid), 32'h1);
        chk("stall_payload_kept", 32'({ev_err, ev_nibble, ev_digit}), 32'(held));
        chk("stall_no_accept", 32'(evq.size() - base), 32'h0);
        ev_ready = 1'b1;
        n = 0;
        while (evq.size() < base + 6 && n < 40) begin
            step(1);
            n++;
        end
        step(10);
        chk("all_ev_count", 32'(evq.size() - base), 32'h6);
        if (evq.size() >= base + 6) begin
            chk("all_first_is_held", 32'(evq[base]), 32'(held));
            for (int j = 0; j < 6; j++) begin
                int d;
                d = (int'(held[2:0]) + j) % 6;
                chk($sformatf("all_ev%0d", j), 32'(evq[base + j]), 32'(ev(1'b0, nib_exp[d], 3'(d))));
            end
        end

        // Digit 4: legal '5', then an illegal pattern, then blank (illegal to illegal).
        base = evq.size();
        seg_in[28 +: 7] = 7'h12;
        n = 0;
        while (evq.size() == base && n < 20) begin
            step(1);
            n++;
        end
        step(2);
        chk("d4_five_count", 32'(evq.size() - base), 32'h1);
        if (evq.size() > base) chk("d4_five_ev", 32'(evq[base]), 32'(ev(1'b0, 4'h5, 3'd4)));
        base = evq.size();
        seg_in[28 +: 7] = 7'h55;
        n = 0;
        while (evq.size() == base && n < 20) begin
            step(1);
            n++;
        end
        step(2);
        chk("d4_bad_count", 32'(evq.size() - base), 32'h1);
        if (evq.size() > base) chk("d4_bad_ev", 32'(evq[base]), 32'(ev(1'b1, 4'h0, 3'd4)));
        chk("d4_bad_ok", 32'(digit_ok), 32'h2F);
        chk("d4_bad_value", 32'(value), 32'hF0EA83);
        base = evq.size();
        seg_in[28 +: 7] = 7'h7F;
        step(15);
        chk("d4_blank_no_ev", 32'(evq.size() - base), 32'h0);

        // Reset while an event is held: drops it at once and nothing follows release.
        ev_ready = 1'b0;
        seg_in[7 +: 7] = 7'h79;
        n = 0;
        while (!ev_valid && n < 20) begin
            step(1);
            n++;
        end
        chk("hold_before_rst", 32'({ev_valid, ev_err, ev_nibble, ev_digit}), 32'({1'b1, ev(1'b0, 4'h1, 3'd1)}));
        reset = 1'b1;
        seg_in = {6{7'h7F}};
        #1;
        chk("rst_async_valid", 32'(ev_valid), 32'h0);
        chk("rst_async_value", 32'(value), 32'h0);
        step(2);
        reset = 1'b0;
        ev_ready = 1'b1;
        base = evq.size();
        vbase = vcount;
        step(20);
        chk("post_rst_events", 32'(evq.size() - base), 32'h0);
        chk("post_rst_vcount", 32'(vcount - vbase), 32'h0);
        chk("post_rst_ok", 32'(digit_ok), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
